uart_cmd_bridge: RTL and testbench

- ASCII command interpreter between the UART FIFO wrapper and the DMM register bus.
- Pops received bytes from the RX FIFO and parses hex read/write commands.
- Runs one register-bus transaction per command, then pushes an ASCII reply into the TX FIFO.
- Lets a host terminal read and write DMM control/status registers over the serial link.

---
 rtl/uart_cmd_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// ASCII command interpreter: pops hex R/W commands from the RX FIFO, runs one
// register-bus transaction per command and queues the ASCII reply to the TX FIFO.
module uart_cmd_bridge #(
  parameter int unsigned pTimeoutCycles = 32'd12_000_000
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oRxEn,
  input  logic        iRxEmpty,
  input  logic [7:0]  iRxData,
  output logic        oTxEn,
  input  logic        iTxFull,
  output logic [7:0]  oTxData,
  output logic [7:0]  oRegAddr,
  output logic [15:0] oRegWrData,
  output logic        oRegWr,
  output logic        oRegRd,
  input  logic [15:0] iRegRdData,
  output logic        oBusy,
  output logic        oCmdErr
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, PARSE, EXEC_RD, WAIT_RD, EXEC_WR, RESP
  } state_t;

  localparam bit          TMO_ON   = (pTimeoutCycles != 32'd0);
  localparam logic [31:0] TMO_LAST = TMO_ON ? (pTimeoutCycles - 32'd1) : 32'd0;

  // {valid, nibble} for an ASCII hex digit of either case
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'd0;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] resp_byte(input logic [47:0] r, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = r[47:40];
      3'd1:    b = r[39:32];
      3'd2:    b = r[31:24];
      3'd3:    b = r[23:16];
      3'd4:    b = r[15:8];
      3'd5:    b = r[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t      state;
  logic [7:0]  ch;
  logic        pend;
  logic        err;
  logic        is_wr;
  logic [2:0]  dcnt;
  logic [23:0] cmd_buf;
  logic [47:0] resp;
  logic [2:0]  resp_len;
  logic [2:0]  idx;
  logic [31:0] tmo_cnt;

  logic        hex_ok;
  logic [3:0]  hex_nib;
  logic        is_term;
  logic        is_rd_letter;
  logic        is_wr_letter;
  logic [2:0]  need;

  assign {hex_ok, hex_nib} = hex_decode(ch);
  assign is_term      = (ch == 8'h0D) || (ch == 8'h0A);
  assign is_rd_letter = (ch == 8'h52) || (ch == 8'h72);
  assign is_wr_letter = (ch == 8'h57) || (ch == 8'h77);
  assign need         = is_wr ? 3'd6 : 3'd2;

  // The full flag must be honoured in the same cycle the write is presented,
  // so the strobe is gated combinationally; the data byte itself is registered.
  assign oTxEn = (state == RESP) && !iTxFull;

  // Command FSM: fetch, parse, execute and reply
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      ch         <= 8'h00;
      pend       <= 1'b0;
      err        <= 1'b0;
      is_wr      <= 1'b0;
      dcnt       <= 3'd0;
      cmd_buf    <= 24'h000000;
      resp       <= 48'h0;
      resp_len   <= 3'd0;
      idx        <= 3'd0;
      tmo_cnt    <= 32'd0;
      oRxEn      <= 1'b0;
      oTxData    <= 8'h00;
      oRegAddr   <= 8'h00;
      oRegWrData <= 16'h0000;
      oRegWr     <= 1'b0;
      oRegRd     <= 1'b0;
      oBusy      <= 1'b0;
      oCmdErr    <= 1'b0;
    end else begin
      oRxEn   <= 1'b0;
      oRegRd  <= 1'b0;
      oRegWr  <= 1'b0;
      oCmdErr <= 1'b0;
      oBusy   <= 1'b1;
      case (state)
        IDLE: begin
          if (!iRxEmpty) begin
            oRxEn   <= 1'b1;
            tmo_cnt <= 32'd0;
            state   <= FETCH;
          end else if (pend && TMO_ON) begin
            if (tmo_cnt == TMO_LAST) begin
              pend    <= 1'b0;
              err     <= 1'b0;
              tmo_cnt <= 32'd0;
              oBusy   <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end else begin
            oBusy <= pend;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          ch    <= iRxData;
          state <= PARSE;
        end
        PARSE: begin
          if (is_term) begin
            pend <= 1'b0;
            err  <= 1'b0;
            if (!pend) begin
              state <= IDLE;
              oBusy <= 1'b0;
            end else if (err || dcnt != need) begin
              resp     <= {8'h3F, 8'h0D, 8'h0A, 24'h000000};
              resp_len <= 3'd3;
              idx      <= 3'd0;
              oTxData  <= 8'h3F;
              oCmdErr  <= 1'b1;
              state    <= RESP;
            end else if (is_wr) begin
              oRegAddr   <= cmd_buf[23:16];
              oRegWrData <= cmd_buf[15:0];
              oRegWr     <= 1'b1;
              state      <= EXEC_WR;
            end else begin
              oRegAddr <= cmd_buf[7:0];
              oRegRd   <= 1'b1;
              state    <= EXEC_RD;
            end
          end else begin
            pend  <= 1'b1;
            state <= IDLE;
            if (!pend) begin
              dcnt    <= 3'd0;
              cmd_buf <= 24'h000000;
              is_wr   <= is_wr_letter;
              err     <= !(is_rd_letter || is_wr_letter);
            end else if (err) begin
              err <= 1'b1;
            end else if (hex_ok && dcnt < need) begin
              cmd_buf <= {cmd_buf[19:0], hex_nib};
              dcnt    <= dcnt + 3'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXEC_RD: state <= WAIT_RD;
        WAIT_RD: begin
          resp     <= {to_ascii(iRegRdData[15:12]), to_ascii(iRegRdData[11:8]),
                       to_ascii(iRegRdData[7:4]), to_ascii(iRegRdData[3:0]), 8'h0D, 8'h0A};
          resp_len <= 3'd6;
          idx      <= 3'd0;
          oTxData  <= to_ascii(iRegRdData[15:12]);
          state    <= RESP;
        end
        EXEC_WR: begin
          resp     <= {8'h4B, 8'h0D, 8'h0A, 24'h000000};
          resp_len <= 3'd3;
          idx      <= 3'd0;
          oTxData  <= 8'h4B;
          state    <= RESP;
        end
        RESP: begin
          if (!iTxFull) begin
            if (idx == resp_len - 3'd1) begin
              oTxData <= 8'h00;
              oBusy   <= 1'b0;
              state   <= IDLE;
            end else begin
              idx     <= idx + 3'd1;
              oTxData <= resp_byte(resp, idx + 3'd1);
            end
          end else begin
            idx <= idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: an RX FIFO / TX FIFO / register-bus
// environment plus a line-level reference model of the command grammar.
module tb_uart_cmd_bridge;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        oRxEn;
  logic        iRxEmpty;
  logic [7:0]  iRxData;
  logic        oTxEn;
  logic        iTxFull;
  logic [7:0]  oTxData;
  logic [7:0]  oRegAddr;
  logic [15:0] oRegWrData;
  logic        oRegWr;
  logic        oRegRd;
  logic [15:0] iRegRdData;
  logic        oBusy;
  logic        oCmdErr;

  always #5 iClk = ~iClk;

  uart_cmd_bridge #(.pTimeoutCycles(100)) dut (
    .iClk(iClk), .iRst(iRst), .oRxEn(oRxEn), .iRxEmpty(iRxEmpty), .iRxData(iRxData),
    .oTxEn(oTxEn), .iTxFull(iTxFull), .oTxData(oTxData), .oRegAddr(oRegAddr),
    .oRegWrData(oRegWrData), .oRegWr(oRegWr), .oRegRd(oRegRd), .iRegRdData(iRegRdData),
    .oBusy(oBusy), .oCmdErr(oCmdErr)
  );

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [24:0] exp_bus[$];
  logic [15:0] bus_mem[256];
  logic [15:0] ref_mem[256];
  logic        rx_pop_pend = 1'b0;
  int          full_mode = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          tx_seen = 0;
  int          rx_pops = 0;
  int          err_seen = 0;
  int          err_exp = 0;
  string       hex_chars = "0123456789ABCDEF";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event with value %0h", name, act);
  endtask

  // RX FIFO with a registered read port, plus the TX-full pattern generator
  always @(posedge iClk) begin
    #1;
    if (rx_pop_pend && rx_q.size() > 0) iRxData = rx_q.pop_front();
    iRxEmpty = (rx_q.size() == 0);
    if (full_mode == 0) iTxFull = 1'b0;
    else if (full_mode == 1) iTxFull = 1'b1;
    else iTxFull = ($urandom_range(0, 3) == 0);
  end

  // Monitor: every DUT output event is checked against the scoreboard queues
  always @(negedge iClk) begin
    rx_pop_pend = oRxEn;
    if (oRxEn) begin
      rx_pops++;
      check("rx_pop_when_empty", 64'(iRxEmpty), 64'(0));
    end
    if (oTxEn) begin
      tx_seen++;
      check("tx_while_full", 64'(iTxFull), 64'(0));
      if (exp_tx.size() == 0) unexpected("tx_byte", 64'(oTxData));
      else check("tx_byte", 64'(oTxData), 64'(exp_tx.pop_front()));
    end
    if (oRegRd) begin
      iRegRdData = bus_mem[oRegAddr];
      if (exp_bus.size() == 0) unexpected("reg_rd", 64'(oRegAddr));
      else check("reg_rd", 64'({1'b0, oRegAddr, 16'h0000}), 64'(exp_bus.pop_front()));
    end
    if (oRegWr) begin
      bus_mem[oRegAddr] = oRegWrData;
      if (exp_bus.size() == 0) unexpected("reg_wr", 64'({oRegAddr, oRegWrData}));
      else check("reg_wr", 64'({1'b1, oRegAddr, oRegWrData}), 64'(exp_bus.pop_front()));
    end
    if (oCmdErr) err_seen++;
  end

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return int'(c) - 55;
  endfunction

  // Reference model: judge one complete line and queue the responses it implies
  task automatic model_line(input logic [7:0] ln[$]);
    int need;
    bit ok;
    int unsigned v;
    logic [7:0] a;
    logic [7:0] c0;
    logic [15:0] d;
    if (ln.size() == 0) return;
    ok = 1'b1;
    need = 0;
    v = 0;
    c0 = ln[0];
    if (c0 == "R" || c0 == "r") need = 2;
    else if (c0 == "W" || c0 == "w") need = 6;
    else ok = 1'b0;
    if (ln.size() - 1 != need) ok = 1'b0;
    for (int i = 1; i < ln.size(); i++) begin
      if (!is_hex(ln[i])) ok = 1'b0;
      else v = v * 16 + hex_val(ln[i]);
    end
    if (!ok) begin
      exp_tx.push_back("?"); exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
      err_exp++;
    end else if (need == 2) begin
      a = v[7:0];
      d = ref_mem[a];
      exp_bus.push_back({1'b0, a, 16'h0000});
      for (int k = 3; k >= 0; k--) exp_tx.push_back(hex_chars[(d >> (4 * k)) & 16'hF]);
      exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
    end else begin
      a = v[23:16];
      d = v[15:0];
      exp_bus.push_back({1'b1, a, d});
      ref_mem[a] = d;
      exp_tx.push_back("K"); exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0A);
    end
  endtask

  // term: 0 = CR, 1 = LF, 2 = CR LF
  task automatic send_line(input logic [7:0] q[$], input int term);
    foreach (q[i]) rx_q.push_back(q[i]);
    if (term != 1) rx_q.push_back(8'h0D);
    if (term != 0) rx_q.push_back(8'h0A);
    model_line(q);
  endtask

  task automatic send_str(input string s, input int term);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_line(q, term);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge iClk); #1;
      n++;
    end while (!(exp_tx.size() == 0 && exp_bus.size() == 0 && rx_q.size() == 0 &&
                 iRxEmpty && !oBusy) && n < 20000);
    check({name, "_completes"}, 64'(n < 20000), 64'(1));
    check({name, "_cmd_err_count"}, 64'(err_seen), 64'(err_exp));
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 64'({oRxEn, oTxEn, oTxData, oRegAddr, oRegWrData, oRegWr, oRegRd, oBusy, oCmdErr}),
          64'(0));
  endtask

  task automatic rand_line();
    logic [7:0] q[$];
    int kind;
    int n;
    bit lo;
    int d;
    logic [7:0] c;
    lo = 1'($urandom_range(0, 1));
    kind = $urandom_range(0, 7);
    case (kind)
      0, 1, 2: begin q.push_back(lo ? "r" : "R"); n = 2; end
      3, 4:    begin q.push_back(lo ? "w" : "W"); n = 6; end
      5:       begin q.push_back("X"); n = 2; end
      6:       begin q.push_back("R"); n = $urandom_range(3, 5); end
      default: begin q.push_back("W"); n = 6; end
    endcase
    for (int i = 0; i < n; i++) begin
      d = $urandom_range(0, 15);
      c = hex_chars[d];
      if (lo && d > 9) c = c + 8'd32;
      q.push_back(c);
    end
    if (kind == 7) q[$urandom_range(1, 6)] = "G";
    send_line(q, $urandom_range(0, 2));
  endtask

  initial begin
    int base_tx;
    int base_err;
    int base_pops;
    int n;
    logic [15:0] v;
    iRst = 1'b1;
    iRxEmpty = 1'b1;
    iRxData = 8'h00;
    iTxFull = 1'b0;
    iRegRdData = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      bus_mem[i] = v;
      ref_mem[i] = v;
    end
    bus_mem[8'h1A] = 16'hBEEF;
    ref_mem[8'h1A] = 16'hBEEF;
    repeat (3) @(posedge iClk);
    @(negedge iClk); #1;
    check_idle_outputs("reset_outputs");
    iRst = 1'b0;

    send_str("R1A", 0);
    drain("read_1a");
    send_str("w0512ab", 2);
    drain("write_05");
    check("write_landed", 64'(bus_mem[8'h05]), 64'(16'h12AB));
    send_str("X12", 0);
    drain("bad_letter");
    send_str("R1G", 0);
    drain("bad_hex");
    send_str("R123", 0);
    drain("read_too_long");
    send_str("W0102", 0);
    drain("write_too_short");

    // Back-pressure: reply held while the TX FIFO is full, RX left untouched
    full_mode = 1;
    base_tx = tx_seen;
    send_str("R44", 0);
    repeat (30) @(negedge iClk);
    send_str("R55", 0);
    base_pops = rx_pops;
    repeat (50) @(negedge iClk);
    #1;
    check("bp_no_tx_while_full", 64'(tx_seen), 64'(base_tx));
    check("bp_rx_not_popped", 64'(rx_pops), 64'(base_pops));
    full_mode = 0;
    drain("back_pressure");

    // Timeout: a stale partial command is discarded silently
    base_tx = tx_seen;
    base_err = err_seen;
    rx_q.push_back("R");
    rx_q.push_back("1");
    repeat (50) @(negedge iClk);
    #1;
    check("timeout_partial_busy", 64'(oBusy), 64'(1));
    repeat (100) @(negedge iClk);
    #1;
    check("timeout_partial_cleared", 64'(oBusy), 64'(0));
    check("timeout_no_reply", 64'(tx_seen), 64'(base_tx));
    check("timeout_no_err", 64'(err_seen), 64'(base_err));
    send_str("R22", 0);
    drain("after_timeout");

    // Reset after the second reply byte of a read
    base_tx = tx_seen;
    send_str("R33", 0);
    n = 0;
    do begin
      @(negedge iClk); #1;
      n++;
    end while (tx_seen < base_tx + 2 && n < 2000);
    check("reset_reached_2nd_byte", 64'(tx_seen), 64'(base_tx + 2));
    iRst = 1'b1;
    exp_tx.delete();
    @(negedge iClk); #1;
    check_idle_outputs("mid_reply_reset_outputs");
    @(negedge iClk); #1;
    iRst = 1'b0;
    repeat (10) @(negedge iClk);
    #1;
    check("reset_no_more_tx", 64'(tx_seen), 64'(base_tx + 2));
    send_str("R00", 0);
    drain("after_reset");

    // Randomized traffic with random TX back-pressure
    full_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rand_line();
      repeat ($urandom_range(0, 30)) @(negedge iClk);
    end
    drain("random_traffic");
    full_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
